// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master data-RAM arbiter: master indices,
// lock FSM state encoding and the default byte-strobe width.
package mem_bus_pkg;

   localparam int M_CORE = 0;
   localparam int M_DBG  = 1;
   localparam int NUM_M  = 2;

   localparam int DEF_DW = 32;
   localparam int STRB_W = DEF_DW / 8;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

endpackage

// File: rtl/rr_lock_ctrl.sv
// Round-robin arbitration with a bounded bus lock. Produces the one-hot (or
// empty) grant vector combinationally from the current requests; tracks the
// last granted master, the lock owner and the number of locked cycles.
module rr_lock_ctrl
   import mem_bus_pkg::*;
#(
   parameter int LOCK_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output logic [1:0] gnt
);

   localparam int            CW      = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   lock_state_t   lock_state, lock_state_n;
   logic          lock_owner, lock_owner_n;
   logic [CW-1:0] lock_cnt,   lock_cnt_n;
   logic          last_gnt,   last_gnt_n;
   // Set by a forced release; blocks the evicted owner from re-locking on
   // its next grant while the other master is still waiting.
   logic          no_relock,  no_relock_n;

   logic          gnt_any;
   logic          gnt_idx;
   logic          gnt_lock;
   logic          other_req;
   logic          owner_lock;
   logic          deny_relock;

   assign gnt_any    = |gnt;
   assign gnt_idx    = gnt[M_DBG];
   assign gnt_lock   = gnt_idx ? lock[M_DBG] : lock[M_CORE];
   assign other_req  = gnt_idx ? req[M_CORE] : req[M_DBG];
   assign owner_lock = lock_owner ? lock[M_DBG] : lock[M_CORE];

   // Grant decision: owner-only while locked, otherwise round-robin on ties.
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (lock_state == LOCKED) begin
            if (lock_owner) gnt[M_DBG]  = req[M_DBG];
            else            gnt[M_CORE] = req[M_CORE];
         end else if (req == 2'b11) begin
            if (last_gnt) gnt[M_CORE] = 1'b1;
            else          gnt[M_DBG]  = 1'b1;
         end else begin
            gnt = req;
         end
      end
   end

   // Next-state for the round-robin pointer and the lock FSM.
   always_comb begin
      lock_state_n = lock_state;
      lock_owner_n = lock_owner;
      lock_cnt_n   = lock_cnt;
      last_gnt_n   = last_gnt;
      no_relock_n  = no_relock;
      deny_relock  = no_relock && (gnt_idx == lock_owner) && other_req;
      case (lock_state)
         UNLOCKED: begin
            if (gnt_any) begin
               last_gnt_n = gnt_idx;
               if (gnt_idx == lock_owner) no_relock_n = 1'b0;
               if (gnt_lock && !deny_relock) begin
                  lock_state_n = LOCKED;
                  lock_owner_n = gnt_idx;
                  lock_cnt_n   = CNT_ONE;
                  no_relock_n  = 1'b0;
               end
            end
         end
         LOCKED: begin
            if (!owner_lock || (lock_cnt == CNT_MAX)) begin
               lock_state_n = UNLOCKED;
               lock_cnt_n   = '0;
               last_gnt_n   = lock_owner;
               no_relock_n  = (lock_cnt == CNT_MAX);
            end else begin
               lock_cnt_n = lock_cnt + CNT_ONE;
            end
         end
         default: begin
            lock_state_n = UNLOCKED;
            lock_cnt_n   = '0;
         end
      endcase
   end

   // Arbitration state register; master 1 counts as last winner after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_state <= UNLOCKED;
         lock_owner <= 1'b0;
         lock_cnt   <= '0;
         last_gnt   <= 1'b1;
         no_relock  <= 1'b0;
      end else begin
         lock_state <= lock_state_n;
         lock_owner <= lock_owner_n;
         lock_cnt   <= lock_cnt_n;
         last_gnt   <= last_gnt_n;
         no_relock  <= no_relock_n;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of the single-port data RAM. The granted
// master's request is muxed straight onto the slave port in the same cycle;
// read data returning one cycle later is steered to the master that issued it.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_wstrb,
   input  logic            m0_lock,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,

   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_wstrb,
   input  logic            m1_lock,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,

   output logic            s_en,
   output logic            s_we,
   output logic [AW-1:0]   s_addr,
   output logic [DW-1:0]   s_wdata,
   output logic [DW/8-1:0] s_wstrb,
   input  logic [DW-1:0]   s_rdata
);

   logic [NUM_M-1:0] gnt;
   logic             rd_owner_v;
   logic             rd_owner;

   rr_lock_ctrl #(
      .LOCK_MAX (LOCK_MAX)
   ) u_ctrl (
      .clk  (clk),
      .rst  (rst),
      .req  ({m1_req, m0_req}),
      .lock ({m1_lock, m0_lock}),
      .gnt  (gnt)
   );

   assign m0_gnt = gnt[M_CORE];
   assign m1_gnt = gnt[M_DBG];
   assign s_en   = |gnt;

   // Slave request mux; an idle bus drives all-zero controls and data.
   always_comb begin
      s_we    = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      if (gnt[M_DBG]) begin
         s_we    = m1_we;
         s_addr  = m1_addr;
         s_wdata = m1_wdata;
         s_wstrb = m1_wstrb;
      end else if (gnt[M_CORE]) begin
         s_we    = m0_we;
         s_addr  = m0_addr;
         s_wdata = m0_wdata;
         s_wstrb = m0_wstrb;
      end
   end

   // Remember who issued a granted read so next cycle's data goes back to it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_owner_v <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_owner_v <= s_en & ~s_we;
         if (s_en & ~s_we) rd_owner <= gnt[M_DBG];
      end
   end

   assign m0_rvalid = rd_owner_v & ~rst & ~rd_owner;
   assign m1_rvalid = rd_owner_v & ~rst &  rd_owner;
   assign m0_rdata  = m0_rvalid ? s_rdata : '0;
   assign m1_rdata  = m1_rvalid ? s_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a cycle-level reference model checks
// grants and slave drive, queues expected read returns, and an independent
// monitor compares every rvalid/rdata against that queue.
module tb_mem_bus_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int LOCK_MAX = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_wstrb, m1_wstrb;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          s_en, s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [3:0]    s_wstrb;
   logic [DW-1:0] s_rdata;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int            due;
      int            m;
      logic [DW-1:0] data;
   } rd_t;
   rd_t rq[$];

   always #5 clk = ~clk;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata)
   );

   // RAM read data is a known function of the cycle it is presented in.
   function automatic logic [DW-1:0] rdata_for(input int n);
      return (32'(n) * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
   endfunction

   assign s_rdata = rdata_for(cyc);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model state: last winner, lock owner (-1 = none), locked-cycle
   // count and the master barred from re-locking after an eviction.
   int last_w = 1;
   int owner  = -1;
   int lcnt   = 0;
   int nr_who = -1;

   always @(negedge clk) begin : model
      int       g;
      logic [1:0] rqv, lkv;
      logic       exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
      logic [3:0]    exp_wstrb;
      bit            deny;
      rqv = {m1_req, m0_req};
      lkv = {m1_lock, m0_lock};
      if (rst) begin
         last_w = 1; owner = -1; lcnt = 0; nr_who = -1; g = -1;
         rq.delete();
      end else if (owner >= 0) begin
         g = rqv[owner] ? owner : -1;
      end else if (rqv == 2'b11) begin
         g = 1 - last_w;
      end else if (rqv[0]) begin
         g = 0;
      end else if (rqv[1]) begin
         g = 1;
      end else begin
         g = -1;
      end
      exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
      if (g == 0) begin
         exp_we = m0_we; exp_addr = m0_addr; exp_wdata = m0_wdata; exp_wstrb = m0_wstrb;
      end else if (g == 1) begin
         exp_we = m1_we; exp_addr = m1_addr; exp_wdata = m1_wdata; exp_wstrb = m1_wstrb;
      end
      check("m0_gnt", m0_gnt, g == 0);
      check("m1_gnt", m1_gnt, g == 1);
      check("s_en", s_en, g >= 0);
      check("s_we", s_we, exp_we);
      check("s_addr", s_addr, exp_addr);
      check("s_wdata", s_wdata, exp_wdata);
      check("s_wstrb", s_wstrb, exp_wstrb);
      if (!rst) begin
         if (g >= 0 && !exp_we) rq.push_back('{cyc + 1, g, rdata_for(cyc + 1)});
         if (owner >= 0) begin
            if (!lkv[owner] || lcnt == LOCK_MAX) begin
               nr_who = (lcnt == LOCK_MAX) ? owner : -1;
               last_w = owner; owner = -1; lcnt = 0;
            end else begin
               lcnt++;
            end
         end else if (g >= 0) begin
            deny   = (nr_who == g) && rqv[1 - g];
            last_w = g;
            if (nr_who == g) nr_who = -1;
            if (lkv[g] && !deny) begin
               owner = g; lcnt = 1; nr_who = -1;
            end
         end
      end
   end

   // Read-return monitor: pops whatever the model expected for this cycle.
   always @(negedge clk) begin : monitor
      bit            e0, e1;
      logic [DW-1:0] d0, d1;
      rd_t           e;
      e0 = 0; e1 = 0; d0 = '0; d1 = '0;
      if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
         e = rq.pop_front();
         if (e.m == 0) begin e0 = 1; d0 = e.data; end
         else          begin e1 = 1; d1 = e.data; end
      end
      check("m0_rvalid", m0_rvalid, e0);
      check("m1_rvalid", m1_rvalid, e1);
      check("m0_rdata", m0_rdata, d0);
      check("m1_rdata", m1_rdata, d1);
   end

   // Observe this cycle's grants, then advance to just after the next edge.
   task automatic tick_g(output logic g0, output logic g1);
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic new_txn(output logic we, output logic [AW-1:0] a,
                          output logic [DW-1:0] wd, output logic [3:0] st);
      we = $urandom_range(0, 1);
      a  = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
   endtask

   task automatic idle_all();
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout cycle=%0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic g0, g1;
      int   n1;
      bit   seen;
      rst = 1;
      idle_all();
      // Requests during reset must not be granted.
      tick_g(g0, g1);
      m0_req = 1;
      tick_g(g0, g1);
      rst = 0;
      // Single core read.
      m0_we = 0; m0_addr = 32'h10;
      tick_g(g0, g1);
      check("single_read_gnt", g0, 1);
      idle_all();
      tick_g(g0, g1);
      // Loader read alone, leaving master 1 as last winner.
      m1_req = 1; m1_addr = 32'h200;
      tick_g(g0, g1);
      idle_all();
      tick_g(g0, g1);
      // Both masters reading continuously: alternate m0, m1, m0, m1.
      m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h24;
      for (int i = 0; i < 4; i++) begin
         tick_g(g0, g1);
         check("alt_m0_gnt", g0, (i % 2) == 0);
      end
      idle_all();
      tick_g(g0, g1);
      // Locked loader burst with the core waiting.
      m1_req = 1; m1_we = 1; m1_lock = 1; m1_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         m1_addr = 32'(i * 4); m1_wdata = 32'h1000 + 32'(i);
         tick_g(g0, g1);
         check("burst_m1_gnt", g1, 1);
         check("burst_m0_blocked", g0, 0);
         m0_req = 1; m0_we = 0; m0_addr = 32'h30;
      end
      m1_req = 0; m1_lock = 0; m1_we = 0;
      tick_g(g0, g1);
      check("burst_exit_m0", g0, 0);
      tick_g(g0, g1);
      check("burst_after_m0", g0, 1);
      idle_all();
      tick_g(g0, g1);
      // Lock starvation: forced release after LOCK_MAX locked cycles.
      m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h100; m1_wdata = 32'hCAFE; m1_wstrb = 4'hF;
      tick_g(g0, g1);
      n1 = g1 ? 1 : 0;
      m0_req = 1; m0_we = 0; m0_addr = 32'h40;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick_g(g0, g1);
         if (g1) n1++;
         if (g0) seen = 1;
      end
      check("starve_m1_run", 64'(n1), 64'(LOCK_MAX + 1));
      check("starve_m0_seen", seen, 1);
      repeat (6) tick_g(g0, g1);
      idle_all();
      repeat (2) tick_g(g0, g1);
      // Reset asserted the cycle after a granted core read.
      m0_req = 1; m0_addr = 32'h50;
      tick_g(g0, g1);
      idle_all();
      rst = 1;
      tick_g(g0, g1);
      m0_req = 1; m1_req = 1;
      tick_g(g0, g1);
      check("reset_no_gnt", {g1, g0}, 2'b00);
      rst = 0;
      m0_addr = 32'h60; m1_addr = 32'h64;
      tick_g(g0, g1);
      check("post_reset_m0_wins", {g1, g0}, 2'b01);
      idle_all();
      tick_g(g0, g1);
      // Byte-strobed core write.
      m0_req = 1; m0_we = 1; m0_addr = 32'h70; m0_wdata = 32'h0000AB00; m0_wstrb = 4'b0010;
      tick_g(g0, g1);
      check("strobe_write_gnt", g0, 1);
      idle_all();
      repeat (2) tick_g(g0, g1);
      // Randomized traffic; a master holds its request until granted.
      g0 = 0; g1 = 0;
      for (int i = 0; i < 800; i++) begin
         if (!m0_req || g0) begin
            m0_req = ($urandom_range(0, 99) < 60);
            new_txn(m0_we, m0_addr, m0_wdata, m0_wstrb);
         end
         if (!m1_req || g1) begin
            m1_req = ($urandom_range(0, 99) < 50);
            new_txn(m1_we, m1_addr, m1_wdata, m1_wstrb);
         end
         if ($urandom_range(0, 15) == 0) m0_lock = ~m0_lock;
         if ($urandom_range(0, 7) == 0)  m1_lock = ~m1_lock;
         tick_g(g0, g1);
      end
      idle_all();
      repeat (3) tick_g(g0, g1);
      check("rd_queue_drained", 64'(rq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter sharing the SoC's single-port data RAM.
- Master 0 is the core load/store port. Master 1 is the debug/program loader, which fills RAM before the core runs and pokes memory while the testbench is active.
- Round-robin grant with an optional bounded bus lock for loader bursts.
- Routes 1-cycle-latency read data back to the master that issued the read.

Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width; DW/8 byte strobes
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 requests an access this cycle
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  AW  byte address
- m0_wdata  in  DW  write data
- m0_wstrb  in  DW/8  byte enables for writes
- m0_lock  in  1  request to keep the bus after this grant
- m0_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid  out  1  read data valid, one cycle after a granted read
- m0_rdata  out  DW  read data; 0 when m0_rvalid=0
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- s_en  out  1  slave access strobe
- s_we  out  1  slave write enable
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_wstrb  out  DW/8  slave byte enables
- s_rdata  in  DW  slave read data, valid the cycle after s_en & ~s_we

Behaviour:
- Reset state (asynchronous): last_gnt=1, so master 0 wins the first tie. lock_state=UNLOCKED, lock_cnt=0, rd_owner_v=0, rd_owner=0.
- Outputs during reset: all m*_gnt, m*_rvalid and s_en are 0; all m*_rdata are 0.
- Grant logic is combinational in the request cycle:
  - If only one master requests, it is granted.
  - If both request, the master not equal to last_gnt is granted.
  - At most one gnt is high per cycle.
- Slave drive: s_en = |gnt. s_we, s_addr, s_wdata and s_wstrb are muxed from the granted master. With no grant, s_we, s_addr, s_wdata and s_wstrb are 0.
- last_gnt updates at clk rise to the granted master whenever any grant occurs.
- Read return:
  - A granted read sets rd_owner_v=1 and rd_owner=granted master at clk rise.
  - The next cycle, m<rd_owner>_rvalid=1 and its rdata=s_rdata. The other master sees rvalid=0 and rdata=0.
  - Back-to-back reads from alternating masters are supported every cycle. Throughput is 1 access per cycle.
- Writes complete in the grant cycle and produce no rvalid.
- Lock FSM, state UNLOCKED:
  - If the granted master has m*_lock=1, go to LOCKED(owner) and set lock_cnt=1.
- Lock FSM, state LOCKED(owner):
  - Only the owner can be granted. The other master's gnt=0 regardless of req.
  - Owner with req=0 and lock=1 keeps the lock with the bus idle.
  - Each cycle in LOCKED increments lock_cnt, saturating at LOCK_MAX.
  - Exit to UNLOCKED when owner lock=0: that cycle's owner req is still granted; the exit takes effect next cycle.
  - Exit to UNLOCKED on forced release when lock_cnt==LOCK_MAX: set last_gnt=owner, so the other master wins the next tie. The owner may not re-lock on its next grant if the other master is requesting that cycle.
  - lock_cnt clears on exit.
- Reset mid-operation: any pending read return is dropped (no rvalid after reset) and the lock is cleared. The slave write of the grant cycle is unaffected by the arbiter.
- Req with gnt=0: the master must hold req, we, addr, wdata and wstrb stable until granted. The arbiter keeps no queue.

Decomposition:
- Shared package mem_bus_pkg:
  - master index localparams M_CORE=0, M_DBG=1
  - lock FSM state encoding (UNLOCKED, LOCKED)
  - strobe width constant
- One sub-module, rr_lock_ctrl: round-robin pointer, lock FSM and lock_cnt. Outputs the grant vector.
- The top level holds the data muxes and the read-owner pipeline register.

Test Plan:
- Reset then single core read: m0_req=1, addr=0x10, s_rdata=0xDEADBEEF -> m0_gnt=1 in the same cycle; m0_rvalid=1 with rdata=0xDEADBEEF one cycle later; m1_rvalid stays 0.
- Both masters request reads continuously for 4 cycles -> grant order m0,m1,m0,m1; each rvalid lands one cycle after its grant on the correct master.
- Loader burst: m1_lock=1 with 4 writes to 0x0..0xC while m0_req is held high -> m0_gnt=0 for all 4 cycles. After m1_lock drops, m0 is granted on the following cycle.
- Lock starvation: m1 holds lock=1 and req=1 for 20 cycles, LOCK_MAX=16, m0_req=1 -> forced release; m0 granted in the cycle after lock_cnt reaches 16; m1 re-granted after that.
- Asynchronous reset asserted the cycle after a granted m0 read -> m0_rvalid never pulses; all gnt=0 while rst=1. After release, m0 wins a simultaneous request.
- Write byte strobes: m0 write with wstrb=4'b0010 and wdata=0x0000AB00 -> s_en=1, s_we=1, s_wstrb=0010 in the grant cycle; no rvalid follows.
